// File: rtl/mmu_tlb_lock_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_tlb_lock_arb_pkg
// Description : Shared types and defaults for the TLB lock arbiter slice:
//               packed lookup word, channel/timeout defaults, lock states.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_tlb_lock_arb_pkg;

  localparam int VADDR_BITS = 48;
  localparam int PID_BITS   = 6;

  // Lookup word steered from the owning FSM onto the TLB port
  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [PID_BITS-1:0]   pid;
    logic                  strm;
    logic                  wr;
  } tlb_lkup_t;

  localparam int TLB_LKUP_BITS = $bits(tlb_lkup_t);

  // Default channel count (rd/wr pair) and watchdog limit in cycles
  localparam int N_TLB_CH     = 2;
  localparam int TLB_LOCK_TMO = 4096;

  typedef enum logic [0:0] {
    LOCK_FREE  = 1'b0,
    LOCK_OWNED = 1'b1
  } lock_state_t;

endpackage : mmu_tlb_lock_arb_pkg
`default_nettype wire

// File: rtl/mmu_tlb_lock_arb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mmu_rr_arb
// Description : Combinational round-robin pick. Returns the first channel
//               with (req & mask) set, scanning upward from ptr and wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_rr_arb #(
  parameter int N      = 2,
  parameter int N_BITS = 1
) (
  input  logic [N-1:0]      req,
  input  logic [N_BITS-1:0] ptr,
  input  logic [N-1:0]      mask,
  output logic              hit,
  output logic [N_BITS-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & mask;

  // Scan N positions starting at ptr; the first candidate found wins
  always_comb begin
    int j;
    hit = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!hit && cand[j]) begin
        hit = 1'b1;
        idx = N_BITS'(j);
      end
    end
  end

endmodule : mmu_rr_arb
`default_nettype wire

// File: rtl/mmu_tlb_lock_arb.sv
`default_nettype none
// ============================================================================
// Module      : mmu_tlb_lock_arb
// Description : N-channel round-robin lock arbiter for the shared TLB with
//               owner lookup mux and hold watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_tlb_lock_arb
  import mmu_tlb_lock_arb_pkg::*;
#(
  parameter int N_CH      = N_TLB_CH,
  parameter int CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int MAX_HOLD  = TLB_LOCK_TMO,
  parameter int LKUP_BITS = TLB_LKUP_BITS
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_CH-1:0]           lock_req,
  input  logic [N_CH-1:0]           unlock,
  output logic [N_CH-1:0]           grant,
  output logic [CH_BITS-1:0]        owner,
  output logic                      locked,
  input  logic [N_CH*LKUP_BITS-1:0] s_lkup,
  input  logic [N_CH-1:0]           s_lkup_valid,
  output logic [LKUP_BITS-1:0]      m_lkup,
  output logic                      m_lkup_valid,
  output logic                      tmo_irq,
  output logic [CH_BITS-1:0]        tmo_ch
);

  // Counter only needs to reach MAX_HOLD-1, where the watchdog fires
  localparam int                HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam bit                WD_EN     = (MAX_HOLD > 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = WD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  lock_state_t         state;
  logic [CH_BITS-1:0]  rr_ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [N_CH-1:0]     owner_oh;
  logic [N_CH-1:0]     arb_mask;
  logic                arb_hit;
  logic [CH_BITS-1:0]  arb_idx;
  logic [N_CH-1:0]     arb_oh;
  logic [CH_BITS-1:0]  ptr_next;
  logic                owner_unlock;
  logic                expire;

  assign owner_oh     = {{(N_CH-1){1'b0}}, 1'b1} << owner;
  assign arb_oh       = {{(N_CH-1){1'b0}}, 1'b1} << arb_idx;
  // During handoff the releasing owner is excluded so it must re-arbitrate later
  assign arb_mask     = (state == LOCK_OWNED) ? ~owner_oh : {N_CH{1'b1}};
  assign ptr_next     = (arb_idx == CH_BITS'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
  assign owner_unlock = unlock[owner];
  assign expire       = WD_EN && (hold_cnt == HOLD_LAST);

  mmu_rr_arb #(
    .N      (N_CH),
    .N_BITS (CH_BITS)
  ) u_rr_arb (
    .req  (lock_req),
    .ptr  (rr_ptr),
    .mask (arb_mask),
    .hit  (arb_hit),
    .idx  (arb_idx)
  );

  // Lock FSM: grant, handoff, release and watchdog with registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= LOCK_FREE;
      grant    <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      tmo_irq  <= 1'b0;
      tmo_ch   <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      tmo_irq <= 1'b0;
      case (state)
        LOCK_FREE: begin
          if (arb_hit) begin
            state    <= LOCK_OWNED;
            grant    <= arb_oh;
            owner    <= arb_idx;
            locked   <= 1'b1;
            rr_ptr   <= ptr_next;
            hold_cnt <= '0;
          end
        end
        LOCK_OWNED: begin
          if (owner_unlock || expire) begin
            // An explicit unlock on the expiry cycle is a normal release
            if (!owner_unlock) begin
              tmo_irq <= 1'b1;
              tmo_ch  <= owner;
            end
            if (arb_hit) begin
              grant    <= arb_oh;
              owner    <= arb_idx;
              rr_ptr   <= ptr_next;
              hold_cnt <= '0;
            end else begin
              state    <= LOCK_FREE;
              grant    <= '0;
              owner    <= '0;
              locked   <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != {HOLD_W{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state  <= LOCK_FREE;
          grant  <= '0;
          owner  <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Owner's lookup goes straight to the TLB; owner is 0 while free
  always_comb begin
    m_lkup       = s_lkup[int'(owner)*LKUP_BITS +: LKUP_BITS];
    m_lkup_valid = locked & s_lkup_valid[owner];
  end

endmodule : mmu_tlb_lock_arb
`default_nettype wire

// File: tb/tb_mmu_tlb_lock_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_tlb_lock_arb
// Description : Self-checking bench for mmu_tlb_lock_arb (4 channels,
//               16-cycle watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_tlb_lock_arb;

  localparam int N  = 4;
  localparam int CB = 2;
  localparam int LB = mmu_tlb_lock_arb_pkg::TLB_LKUP_BITS;
  localparam int MH = 16;

  typedef struct {
    logic [3:0] req;
    logic [3:0] unl;
    logic [3:0] vld;
    logic [3:0] eg;
    logic [1:0] eo;
    logic       el;
    logic       ev;
    logic       et;
    logic [1:0] etc;
  } vec_t;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    lock_req;
  logic [N-1:0]    unlock;
  logic [N-1:0]    grant;
  logic [CB-1:0]   owner;
  logic            locked;
  logic [N*LB-1:0] s_lkup;
  logic [N-1:0]    s_lkup_valid;
  logic [LB-1:0]   m_lkup;
  logic            m_lkup_valid;
  logic            tmo_irq;
  logic [CB-1:0]   tmo_ch;

  logic [LB-1:0]   lk [N];
  vec_t            sb [$];
  vec_t            tbl [12];
  int              total = 0;
  int              bad   = 0;

  always #5 aclk = ~aclk;

  mmu_tlb_lock_arb #(
    .N_CH      (N),
    .CH_BITS   (CB),
    .MAX_HOLD  (MH),
    .LKUP_BITS (LB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .lock_req     (lock_req),
    .unlock       (unlock),
    .grant        (grant),
    .owner        (owner),
    .locked       (locked),
    .s_lkup       (s_lkup),
    .s_lkup_valid (s_lkup_valid),
    .m_lkup       (m_lkup),
    .m_lkup_valid (m_lkup_valid),
    .tmo_irq      (tmo_irq),
    .tmo_ch       (tmo_ch)
  );

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] unl, input logic [3:0] vld,
                              input logic [3:0] eg, input logic [1:0] eo, input logic el,
                              input logic ev, input logic et, input logic [1:0] etc);
    vec_t v;
    v.req = req; v.unl = unl; v.vld = vld; v.eg = eg; v.eo = eo;
    v.el = el; v.ev = ev; v.et = et; v.etc = etc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Pop the expected record pushed by step() and compare every output
  task automatic check_out();
    vec_t e;
    logic [LB-1:0] w;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard @%0t: got empty queue expected one entry", $time);
      return;
    end
    e = sb.pop_front();
    w = lk[e.el ? int'(e.eo) : 0];
    cmp("grant",        64'(grant),        64'(e.eg));
    cmp("owner",        64'(owner),        64'(e.eo));
    cmp("locked",       64'(locked),       64'(e.el));
    cmp("m_lkup_valid", 64'(m_lkup_valid), 64'(e.ev));
    cmp("m_lkup",       64'(m_lkup),       64'(w));
    cmp("tmo_irq",      64'(tmo_irq),      64'(e.et));
    cmp("tmo_ch",       64'(tmo_ch),       64'(e.etc));
  endtask

  task automatic step(input vec_t v);
    lock_req     = v.req;
    unlock       = v.unl;
    s_lkup_valid = v.vld;
    sb.push_back(v);
    @(posedge aclk);
    #1;
    check_out();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_grant"},   64'(grant),        64'd0);
    cmp({tag, "_owner"},   64'(owner),        64'd0);
    cmp({tag, "_locked"},  64'(locked),       64'd0);
    cmp({tag, "_tmo_irq"}, 64'(tmo_irq),      64'd0);
    cmp({tag, "_tmo_ch"},  64'(tmo_ch),       64'd0);
    cmp({tag, "_mvalid"},  64'(m_lkup_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("rst_pulse");
    lock_req = '0; unlock = '0; s_lkup_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Run-time guard so a stuck bench still ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [1:0] cur;
    logic [3:0] oh;

    for (int i = 0; i < N; i++) begin
      lk[i] = LB'(64'h00C0_DE00_1000_0000) + LB'(64'h0111_1111 * (i + 1));
      s_lkup[i*LB +: LB] = lk[i];
    end

    // Basic grant, ignore rules, release, mux and re-arbitration
    tbl[0]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0);
    tbl[1]  = mk(4'b0100, 4'b1000, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    tbl[2]  = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tbl[3]  = mk(4'b0000, 4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tbl[4]  = mk(4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    tbl[5]  = mk(4'b0010, 4'b0000, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    tbl[6]  = mk(4'b0010, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
    tbl[7]  = mk(4'b0011, 4'b0001, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    tbl[8]  = mk(4'b0001, 4'b1000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
    tbl[9]  = mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tbl[10] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    tbl[11] = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    aresetn = 1'b0;
    lock_req = '0; unlock = '0; s_lkup_valid = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 12; i++) step(tbl[i]);

    // All four request continuously; each owner unlocks 3 cycles after grant
    pulse_reset();
    step(mk(4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    cur = 2'd0;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << cur;
      step(mk(4'b1111, 4'b0000, 4'b0000, oh, cur, 1'b1, 1'b0, 1'b0, 2'd0));
      step(mk(4'b1111, 4'b0000, 4'b0000, oh, cur, 1'b1, 1'b0, 1'b0, 2'd0));
      step(mk(4'b1111, oh, 4'b0000, 4'b0001 << (cur + 2'd1), cur + 2'd1, 1'b1, 1'b0, 1'b0, 2'd0));
      cur = cur + 2'd1;
    end

    // Watchdog: channel 2 never unlocks, channel 3 waits
    step(mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    step(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
    for (int k = 0; k < MH - 1; k++)
      step(mk(4'b1100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
    step(mk(4'b1100, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 2'd2));

    // Unlock on the expiry cycle is an ordinary release
    for (int k = 0; k < MH - 1; k++)
      step(mk(4'b0100, 4'b0000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 2'd2));
    step(mk(4'b0100, 4'b1000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2));

    // Reset asserted while channel 3 owns the lock
    step(mk(4'b1000, 4'b0100, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 2'd2));
    aresetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    lock_req = '0; unlock = '0; s_lkup_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    step(mk(4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mmu_tlb_lock_arb
`default_nettype wire
